// File: rtl/section3_ctrl.sv
// Purpose : control FSM for datapath_section3; divides by repeated subtraction of divisor from a1.
// Latency : done/err pulse in the cycle after edge 2Q+2 (edge 0 samples start); divisor==0 fails after edge 2.
// Backpressure: none; start is only sampled in IDLE and ignored while a job is in flight.
//
// Ports:
//   CLK, RST_N          clock (rising edge) and asynchronous active-low reset
//   start               job request, sampled in IDLE only
//   divisor             subtrahend, held stable by the requester while busy
//   a1out               accumulator readback from datapath_section3
//   CTRL3/4/5/8/9       datapath controls (source select, acc write, subtract, mout select, mout write)
//   busy, done, err     job status; done and err are single-cycle pulses
//   quotient, remainder result, valid with done and held until the next result
module section3_ctrl #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] a1out,
  output logic             CTRL3,
  output logic             CTRL4,
  output logic             CTRL5,
  output logic             CTRL8,
  output logic             CTRL9,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // The iteration counter must be able to hold MAX_ITER without wrapping.
  if (MAX_ITER >= (1 << CNT_W) || MAX_ITER < 1) begin : g_bad_max_iter
    $error("section3_ctrl: MAX_ITER must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SUB,
    S_FIN,
    S_FAIL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             finishing;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Iteration counter: cleared when a job is accepted, bumped once per subtraction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (state == S_IDLE && start) begin
      count <= '0;
    end else if (state == S_SUB) begin
      count <= count + 1'b1;
    end
  end

  // Results are captured on the CHECK->FIN/FAIL edge so they are already
  // valid during the done cycle; a1out is final at that point.
  assign finishing = (state == S_CHECK) && (state_nxt == S_FIN || state_nxt == S_FAIL);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (finishing) begin
      quotient  <= count;
      remainder <= a1out;
    end
  end

  // Next state plus state-decoded outputs; outputs depend on state only.
  always_comb begin
    state_nxt = state;
    CTRL3     = 1'b0;
    CTRL4     = 1'b0;
    CTRL5     = 1'b0;
    CTRL8     = 1'b0;
    CTRL9     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        CTRL3     = 1'b1;
        CTRL4     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (divisor == '0) begin
          state_nxt = S_FAIL;
        end else if (count == MAX_CNT) begin
          state_nxt = S_FAIL;
        end else if (a1out >= divisor) begin
          state_nxt = S_SUB;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_SUB: begin
        CTRL4     = 1'b1;
        CTRL5     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_CHECK;
      end
      S_FIN: begin
        CTRL8     = 1'b1;
        CTRL9     = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAIL: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_section3_ctrl.sv
// Purpose : self-checking bench for section3_ctrl with a behavioural datapath_section3 model.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_section3_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start_a, start_b;
  logic [15:0] dividend, divisor;

  logic        c3_a, c4_a, c5_a, c8_a, c9_a, busy_a, done_a, err_a;
  logic [7:0]  quot_a;
  logic [15:0] rem_a;
  logic        c3_b, c4_b, c5_b, c8_b, c9_b, busy_b, done_b, err_b;
  logic [7:0]  quot_b;
  logic [15:0] rem_b;

  logic [15:0] acc_a = '0, mout_a = '0, acc_b = '0, mout_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  section3_ctrl u_dut (
    .CLK(CLK), .RST_N(RST_N), .start(start_a), .divisor(divisor), .a1out(acc_a),
    .CTRL3(c3_a), .CTRL4(c4_a), .CTRL5(c5_a), .CTRL8(c8_a), .CTRL9(c9_a),
    .busy(busy_a), .done(done_a), .err(err_a), .quotient(quot_a), .remainder(rem_a)
  );

  section3_ctrl #(.MAX_ITER(3)) u_small (
    .CLK(CLK), .RST_N(RST_N), .start(start_b), .divisor(divisor), .a1out(acc_b),
    .CTRL3(c3_b), .CTRL4(c4_b), .CTRL5(c5_b), .CTRL8(c8_b), .CTRL9(c9_b),
    .busy(busy_b), .done(done_b), .err(err_b), .quotient(quot_b), .remainder(rem_b)
  );

  // Behavioural datapath_section3: accumulator and mout registers.
  always @(posedge CLK) begin
    if (c4_a) acc_a <= c3_a ? dividend : acc_a - divisor;
    if (c9_a) mout_a <= acc_a;
    if (c4_b) acc_b <= c3_b ? dividend : acc_b - divisor;
    if (c9_b) mout_b <= acc_b;
  end

  // View of whichever DUT the current job targets.
  bit          sel = 1'b0;
  logic        o_c4, o_c5, o_busy, o_done, o_err;
  logic [7:0]  o_quot;
  logic [15:0] o_rem, o_mout;
  always_comb begin
    o_c4   = sel ? c4_b   : c4_a;
    o_c5   = sel ? c5_b   : c5_a;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_err  = sel ? err_b  : err_a;
    o_quot = sel ? quot_b : quot_a;
    o_rem  = sel ? rem_b  : rem_a;
    o_mout = sel ? mout_b : mout_a;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one job on the selected DUT and checks it against the arithmetic model.
  // glitch_edge >= 0 pulses start at that edge while the job is busy.
  task automatic run_job(input bit s, input logic [15:0] dvd, input logic [15:0] dvs,
                         input int glitch_edge);
    int maxit, qt, lat, e, c4n, c5n, busy_bad;
    logic [7:0]  eq;
    logic [15:0] er;
    bit          ee;
    maxit = s ? 3 : 255;
    if (dvs == 0) begin
      eq = 0; er = dvd; ee = 1'b1; lat = 2;
    end else begin
      qt = int'(dvd) / int'(dvs);
      if (qt >= maxit) begin
        eq = 8'(maxit); er = 16'(int'(dvd) - maxit * int'(dvs)); ee = 1'b1; lat = 2 * maxit + 2;
      end else begin
        eq = 8'(qt); er = 16'(int'(dvd) % int'(dvs)); ee = 1'b0; lat = 2 * qt + 2;
      end
    end
    sel = s;
    e = 0; c4n = 0; c5n = 0; busy_bad = 0;
    @(negedge CLK);
    dividend = dvd; divisor = dvs;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge CLK);
    #1 start_a = 1'b0; start_b = 1'b0;
    forever begin
      @(negedge CLK);
      if (o_done) break;
      if (!o_busy) busy_bad++;
      if (o_c4) c4n++;
      if (o_c5) c5n++;
      if (e == glitch_edge) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      @(posedge CLK);
      e++;
      #1 start_a = 1'b0; start_b = 1'b0;
      if (e > lat + 20) begin
        checks++; errors++;
        $display("FAIL job_timeout dvd=%0d dvs=%0d: no done by edge %0d, required edge %0d", dvd, dvs, e, lat);
        return;
      end
    end
    checks++; if (e !== lat) begin errors++; $display("FAIL latency dvd=%0d dvs=%0d: got edge %0d, want %0d", dvd, dvs, e, lat); end
    checks++; if (o_quot !== eq) begin errors++; $display("FAIL quotient dvd=%0d dvs=%0d: got %0d, want %0d", dvd, dvs, o_quot, eq); end
    checks++; if (o_rem !== er) begin errors++; $display("FAIL remainder dvd=%0d dvs=%0d: got %0d, want %0d", dvd, dvs, o_rem, er); end
    checks++; if (o_err !== ee) begin errors++; $display("FAIL err dvd=%0d dvs=%0d: got %0b, want %0b", dvd, dvs, o_err, ee); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_at_done dvd=%0d dvs=%0d: got %0b, want 0", dvd, dvs, o_busy); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_while_running dvd=%0d dvs=%0d: %0d low cycles, want 0", dvd, dvs, busy_bad); end
    checks++; if (c5n !== int'(eq)) begin errors++; $display("FAIL ctrl5_cycles dvd=%0d dvs=%0d: got %0d, want %0d", dvd, dvs, c5n, eq); end
    checks++; if (c4n !== int'(eq) + 1) begin errors++; $display("FAIL ctrl4_cycles dvd=%0d dvs=%0d: got %0d, want %0d", dvd, dvs, c4n, int'(eq) + 1); end
    @(negedge CLK);
    if (!ee) begin
      checks++; if (o_mout !== er) begin errors++; $display("FAIL mout dvd=%0d dvs=%0d: got %0d, want %0d", dvd, dvs, o_mout, er); end
    end
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL idle_after_done dvd=%0d dvs=%0d: busy=%0b done=%0b, want 0 0", dvd, dvs, o_busy, o_done);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; start_a = 1'b0; start_b = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({c3_a, c4_a, c5_a, c8_a, c9_a, busy_a, done_a, err_a} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl_a: got %b, want 00000000", {c3_a, c4_a, c5_a, c8_a, c9_a, busy_a, done_a, err_a});
    end
    checks++;
    if ({quot_a, rem_a} !== 24'h0) begin errors++; $display("FAIL reset_result_a: q=%0d r=%0d, want 0 0", quot_a, rem_a); end
    checks++;
    if ({c3_b, c4_b, c5_b, c8_b, c9_b, busy_b, done_b, err_b, quot_b, rem_b} !== 32'h0) begin
      errors++; $display("FAIL reset_small: outputs nonzero, want all 0");
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_directed;
    run_job(1'b0, 16'd8, 16'd2, -1);
    run_job(1'b0, 16'd6, 16'd4, -1);
    run_job(1'b0, 16'd1, 16'd2, -1);
    run_job(1'b0, 16'd6, 16'd0, -1);
    run_job(1'b0, 16'hFFFF, 16'hFFFF, -1);
    run_job(1'b0, 16'd0, 16'd5, -1);
  endtask

  task automatic test_max_iter;
    run_job(1'b1, 16'd100, 16'd1, -1);
    run_job(1'b1, 16'd9, 16'd3, -1);
    run_job(1'b1, 16'd8, 16'd3, -1);
    run_job(1'b0, 16'd255, 16'd1, -1);
    run_job(1'b0, 16'd254, 16'd1, -1);
  endtask

  task automatic test_reset_mid;
    int done_seen;
    done_seen = 0;
    sel = 1'b0;
    @(negedge CLK);
    dividend = 16'd8; divisor = 16'd2; start_a = 1'b1;
    @(posedge CLK);
    #1 start_a = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if ({c3_a, c4_a, c5_a, c8_a, c9_a, busy_a, done_a, err_a, quot_a, rem_a} !== 32'h0) begin
      errors++; $display("FAIL reset_mid_outputs: busy=%0b done=%0b q=%0d r=%0d, want all 0", busy_a, done_a, quot_a, rem_a);
    end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      if (done_a || busy_a) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL reset_mid_no_done: %0d active cycles, want 0", done_seen); end
    run_job(1'b0, 16'd8, 16'd2, 3);
    run_job(1'b0, 16'd6, 16'd4, 1);
  endtask

  task automatic test_back_to_back;
    int n;
    sel = 1'b0;
    @(negedge CLK);
    dividend = 16'd6; divisor = 16'd4; start_a = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!done_a && n < 50);
    checks++;
    if (!done_a || quot_a !== 8'd1 || rem_a !== 16'd2) begin
      errors++; $display("FAIL b2b_first: done=%0b q=%0d r=%0d, want 1 1 2", done_a, quot_a, rem_a);
    end
    @(negedge CLK);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%0b done=%0b, want 0 0", busy_a, done_a); end
    @(negedge CLK);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_retrigger: busy=%0b, want 1", busy_a); end
    start_a = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!done_a && n < 50);
    checks++;
    if (!done_a || quot_a !== 8'd1 || rem_a !== 16'd2 || err_a !== 1'b0) begin
      errors++; $display("FAIL b2b_second: done=%0b q=%0d r=%0d err=%0b, want 1 1 2 0", done_a, quot_a, rem_a, err_a);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_random;
    int qt, dvs, dvd;
    for (int i = 0; i < 24; i++) begin
      qt = $urandom_range(0, 300);
      if ($urandom_range(0, 7) == 0) begin
        dvs = 0;
        dvd = $urandom_range(0, 65535);
      end else begin
        dvs = $urandom_range(1, 65535 / (qt + 1));
        dvd = dvs * qt + $urandom_range(0, dvs - 1);
      end
      run_job(bit'($urandom_range(0, 1)), 16'(dvd), 16'(dvs), ($urandom_range(0, 1) == 1) ? 2 : -1);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_max_iter;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
